// File: rtl/x3q16_mem_arb.sv
// x3q16_mem_arb: two-port (0 = CPU, 1 = loader) arbiter in front of a single-outstanding memory.
// Define X3Q16_ARB_RR_EN for round-robin tie-breaking; default build gives port 0 fixed priority.
module x3q16_mem_arb #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              p0_request,
  input  logic              p0_request_type,
  input  logic [ADDR_W-1:0] p0_request_address,
  input  logic [DATA_W-1:0] p0_data_out,
  output logic [DATA_W-1:0] p0_memory_in,
  output logic              p0_memory_ready,
  output logic              p0_write_complete,

  input  logic              p1_request,
  input  logic              p1_request_type,
  input  logic [ADDR_W-1:0] p1_request_address,
  input  logic [DATA_W-1:0] p1_data_out,
  output logic [DATA_W-1:0] p1_memory_in,
  output logic              p1_memory_ready,
  output logic              p1_write_complete,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,

  output logic              grant,
  output logic              busy,
  output logic [1:0]        overrun
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
  state_t state;

  logic [1:0]        req_in;
  logic [1:0]        type_in;
  logic [ADDR_W-1:0] addr_in [2];
  logic [DATA_W-1:0] data_in [2];

  assign req_in     = {p1_request, p0_request};
  assign type_in    = {p1_request_type, p0_request_type};
  assign addr_in[0] = p0_request_address;
  assign addr_in[1] = p1_request_address;
  assign data_in[0] = p0_data_out;
  assign data_in[1] = p1_data_out;

  logic [1:0]        slot_vld;
  logic [1:0]        slot_we;
  logic [ADDR_W-1:0] slot_addr  [2];
  logic [DATA_W-1:0] slot_wdata [2];

  logic [1:0]        rdy_q;
  logic [1:0]        wc_q;
  logic [DATA_W-1:0] rdata_q [2];

  logic win;
  logic issue;

`ifdef X3Q16_ARB_RR_EN
  // grant resets to 0, so the first tie after reset needs its own marker to go to port 0
  logic granted_once;
`endif

  assign issue = (state == ST_IDLE) && (slot_vld != 2'b00);

  always_comb begin
    win = 1'b0;
    case (slot_vld)
      2'b10: win = 1'b1;
      2'b11: begin
`ifdef X3Q16_ARB_RR_EN
        win = granted_once ? ~grant : 1'b0;
`else
        win = 1'b0;
`endif
      end
      default: win = 1'b0;
    endcase
  end

  // Pending slots: fill when empty, drop and flag when full; the issue edge frees the winner
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_vld <= 2'b00;
      slot_we  <= 2'b00;
      overrun  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        slot_addr[i]  <= '0;
        slot_wdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (issue && (win == i[0]))
          slot_vld[i] <= 1'b0;
        if (req_in[i]) begin
          if (slot_vld[i]) begin
            overrun[i] <= 1'b1;
          end else begin
            slot_vld[i]   <= 1'b1;
            slot_we[i]    <= type_in[i];
            slot_addr[i]  <= addr_in[i];
            slot_wdata[i] <= data_in[i];
          end
        end
      end
    end
  end

  // Transaction FSM with registered memory-side and response outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      grant      <= 1'b0;
      busy       <= 1'b0;
      rdy_q      <= 2'b00;
      wc_q       <= 2'b00;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
`ifdef X3Q16_ARB_RR_EN
      granted_once <= 1'b0;
`endif
    end else begin
      mem_req <= 1'b0;
      rdy_q   <= 2'b00;
      wc_q    <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            mem_req   <= 1'b1;
            mem_we    <= slot_we[win];
            mem_addr  <= slot_addr[win];
            mem_wdata <= slot_wdata[win];
            grant     <= win;
            busy      <= 1'b1;
            state     <= ST_WAIT;
`ifdef X3Q16_ARB_RR_EN
            granted_once <= 1'b1;
`endif
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
            if (mem_we) begin
              wc_q[grant] <= 1'b1;
            end else begin
              rdata_q[grant] <= mem_rdata;
              rdy_q[grant]   <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign p0_memory_in      = rdata_q[0];
  assign p1_memory_in      = rdata_q[1];
  assign p0_memory_ready   = rdy_q[0];
  assign p1_memory_ready   = rdy_q[1];
  assign p0_write_complete = wc_q[0];
  assign p1_write_complete = wc_q[1];

endmodule

// File: tb/tb_x3q16_mem_arb.sv
// Bench for x3q16_mem_arb: directed scenarios plus randomized traffic against a behavioural model.
// Honours X3Q16_ARB_RR_EN to select the expected tie-break order.
module tb_x3q16_mem_arb;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int OW = 2*DW + 2*AW + 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b1;
  logic          p0_request = 0, p0_request_type = 0, p1_request = 0, p1_request_type = 0;
  logic [AW-1:0] p0_request_address = '0, p1_request_address = '0;
  logic [DW-1:0] p0_data_out = '0, p1_data_out = '0;
  logic [DW-1:0] p0_memory_in, p1_memory_in;
  logic          p0_memory_ready, p1_memory_ready, p0_write_complete, p1_write_complete;
  logic          mem_req, mem_we, mem_ack = 0, grant, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata = '0;
  logic [1:0]    overrun;

  x3q16_mem_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_request(p0_request), .p0_request_type(p0_request_type),
    .p0_request_address(p0_request_address), .p0_data_out(p0_data_out),
    .p0_memory_in(p0_memory_in), .p0_memory_ready(p0_memory_ready),
    .p0_write_complete(p0_write_complete),
    .p1_request(p1_request), .p1_request_type(p1_request_type),
    .p1_request_address(p1_request_address), .p1_data_out(p1_data_out),
    .p1_memory_in(p1_memory_in), .p1_memory_ready(p1_memory_ready),
    .p1_write_complete(p1_write_complete),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .grant(grant), .busy(busy), .overrun(overrun)
  );

  logic [OW-1:0] out_vec;
  assign out_vec = {p0_memory_in, p1_memory_in, p0_memory_ready, p1_memory_ready,
                    p0_write_complete, p1_write_complete, mem_req, mem_we,
                    mem_addr, mem_wdata, grant, busy, overrun};

  int checks = 0;
  int errors = 0;

  // Behavioural reference: one pending request per port, one transaction in flight
  bit   [1:0]    m_v, m_we_s;
  logic [AW-1:0] m_a_s [2];
  logic [DW-1:0] m_d_s [2];
  bit            m_busy, m_port, m_we, m_req;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  int            m_last;
  logic [DW-1:0] m_min [2];
  bit   [1:0]    m_rdy, m_wc, m_ovr;

  function automatic int choose(bit [1:0] pend);
    if (pend == 2'b01) return 0;
    if (pend == 2'b10) return 1;
`ifdef X3Q16_ARB_RR_EN
    if (m_last < 0) return 0;
    return 1 - m_last;
`else
    return 0;
`endif
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    bit   [1:0]    pv, rq, rt;
    logic [AW-1:0] ra [2];
    logic [DW-1:0] rd [2];
    int w;
    if (!reset_n) begin
      m_v = 0; m_we_s = 0; m_busy = 0; m_port = 0; m_we = 0; m_req = 0;
      m_addr = '0; m_wd = '0; m_last = -1; m_rdy = 0; m_wc = 0; m_ovr = 0;
      for (int n = 0; n < 2; n++) begin
        m_a_s[n] = '0; m_d_s[n] = '0; m_min[n] = '0;
      end
    end else begin
      rq = {p1_request, p0_request};
      rt = {p1_request_type, p0_request_type};
      ra[0] = p0_request_address; ra[1] = p1_request_address;
      rd[0] = p0_data_out;        rd[1] = p1_data_out;
      pv = m_v;
      m_req = 0; m_rdy = 0; m_wc = 0;
      if (m_busy) begin
        if (mem_ack) begin
          if (m_we) m_wc[m_port] = 1;
          else begin
            m_min[m_port] = mem_rdata;
            m_rdy[m_port] = 1;
          end
          m_busy = 0;
        end
      end else if (pv != 0) begin
        w = choose(pv);
        m_req = 1; m_busy = 1; m_port = w[0];
        m_we = m_we_s[w]; m_addr = m_a_s[w]; m_wd = m_d_s[w];
        m_last = w;
        m_v[w] = 0;
      end
      for (int n = 0; n < 2; n++) begin
        if (rq[n]) begin
          if (pv[n]) m_ovr[n] = 1;
          else begin
            m_v[n] = 1; m_we_s[n] = rt[n]; m_a_s[n] = ra[n]; m_d_s[n] = rd[n];
          end
        end
      end
    end
  end

  task automatic clear_inputs();
    p0_request = 0; p1_request = 0; p0_request_type = 0; p1_request_type = 0;
    p0_request_address = '0; p1_request_address = '0; p0_data_out = '0; p1_data_out = '0;
    mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    #3 reset_n = 0;
    #1;
    checks++;
    if (out_vec !== '0) begin
      errors++; $display("FAIL reset_async: got %h expected 0", out_vec);
    end
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    checks++;
    if (out_vec !== '0) begin
      errors++; $display("FAIL reset_release: got %h expected 0", out_vec);
    end
  endtask

  task automatic test_read();
    do_reset();
    p0_request = 1; p0_request_type = 0; p0_request_address = 16'h0040;
    @(negedge clk);
    p0_request = 0;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL read_req_early: got %b expected 0", mem_req);
    end
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr, grant, busy} !== {1'b1, 1'b0, 16'h0040, 1'b0, 1'b1}) begin
      errors++; $display("FAIL read_issue: got req=%b we=%b addr=%h g=%b busy=%b expected 1 0 0040 0 1",
                         mem_req, mem_we, mem_addr, grant, busy);
    end
    @(negedge clk);
    checks++;
    if ({mem_req, mem_addr, busy} !== {1'b0, 16'h0040, 1'b1}) begin
      errors++; $display("FAIL read_wait_hold: got req=%b addr=%h busy=%b expected 0 0040 1",
                         mem_req, mem_addr, busy);
    end
    mem_ack = 1; mem_rdata = 16'hBEEF;
    @(negedge clk);
    mem_ack = 0; mem_rdata = '0;
    checks++;
    if ({p0_memory_ready, p1_memory_ready, p0_write_complete, p0_memory_in, busy} !==
        {1'b1, 1'b0, 1'b0, 16'hBEEF, 1'b0}) begin
      errors++; $display("FAIL read_done: got rdy=%b/%b wc=%b data=%h busy=%b expected 1/0 0 beef 0",
                         p0_memory_ready, p1_memory_ready, p0_write_complete, p0_memory_in, busy);
    end
    @(negedge clk);
    checks++;
    if ({p0_memory_ready, p0_memory_in} !== {1'b0, 16'hBEEF}) begin
      errors++; $display("FAIL read_pulse_end: got rdy=%b data=%h expected 0 beef",
                         p0_memory_ready, p0_memory_in);
    end
  endtask

  // Runs straight after test_read, so the last transaction's values are known
  task automatic test_spurious_ack();
    mem_ack = 1; mem_rdata = 16'h5555;
    @(negedge clk);
    mem_ack = 0;
    checks++;
    if ({p0_memory_ready, p1_memory_ready, p0_write_complete, p1_write_complete, busy, mem_req}
        !== 6'b0) begin
      errors++; $display("FAIL spurious_pulse: got %b expected 000000",
        {p0_memory_ready, p1_memory_ready, p0_write_complete, p1_write_complete, busy, mem_req});
    end
    checks++;
    if ({p0_memory_in, mem_addr, mem_we, grant} !== {16'hBEEF, 16'h0040, 1'b0, 1'b0}) begin
      errors++; $display("FAIL spurious_state: got data=%h addr=%h we=%b g=%b expected beef 0040 0 0",
                         p0_memory_in, mem_addr, mem_we, grant);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL spurious_issue: got %b expected 0", mem_req);
    end
  endtask

  task automatic test_write();
    do_reset();
    p1_request = 1; p1_request_type = 0; p1_request_address = 16'h0200;
    @(negedge clk);
    p1_request = 0;
    @(negedge clk);
    mem_ack = 1; mem_rdata = 16'hA5A5;
    @(negedge clk);
    mem_ack = 0;
    checks++;
    if ({p1_memory_ready, p1_memory_in} !== {1'b1, 16'hA5A5}) begin
      errors++; $display("FAIL write_prep_read: got rdy=%b data=%h expected 1 a5a5",
                         p1_memory_ready, p1_memory_in);
    end
    p1_request = 1; p1_request_type = 1; p1_request_address = 16'h0100; p1_data_out = 16'h1234;
    @(negedge clk);
    p1_request = 0;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, grant} !== {1'b1, 1'b1, 16'h0100, 16'h1234, 1'b1}) begin
      errors++; $display("FAIL write_issue: got req=%b we=%b addr=%h wd=%h g=%b expected 1 1 0100 1234 1",
                         mem_req, mem_we, mem_addr, mem_wdata, grant);
    end
    mem_ack = 1; mem_rdata = 16'h9999;
    @(negedge clk);
    mem_ack = 0;
    checks++;
    if ({p1_write_complete, p1_memory_ready, p0_write_complete, p1_memory_in} !==
        {1'b1, 1'b0, 1'b0, 16'hA5A5}) begin
      errors++; $display("FAIL write_done: got wc=%b rdy=%b wc0=%b data=%h expected 1 0 0 a5a5",
                         p1_write_complete, p1_memory_ready, p0_write_complete, p1_memory_in);
    end
    @(negedge clk);
    checks++;
    if (p1_write_complete !== 1'b0) begin
      errors++; $display("FAIL write_pulse_end: got %b expected 0", p1_write_complete);
    end
  endtask

  task automatic test_tie();
    logic [16:0] seen [3];
    logic [16:0] want [3];
`ifdef X3Q16_ARB_RR_EN
    want[0] = {1'b0, 16'h0010}; want[1] = {1'b1, 16'h0020}; want[2] = {1'b0, 16'h0011};
`else
    want[0] = {1'b0, 16'h0010}; want[1] = {1'b0, 16'h0011}; want[2] = {1'b1, 16'h0020};
`endif
    do_reset();
    p0_request = 1; p0_request_address = 16'h0010;
    p1_request = 1; p1_request_address = 16'h0020;
    @(negedge clk);
    p0_request = 0; p1_request = 0;
    @(negedge clk);
    seen[0] = {grant, mem_addr};
    p0_request = 1; p0_request_address = 16'h0011;
    p1_request = 1; p1_request_address = 16'h0021;
    @(negedge clk);
    p0_request = 0; p1_request = 0;
    for (int t = 1; t < 3; t++) begin
      mem_ack = 1;
      @(negedge clk);
      mem_ack = 0;
      @(negedge clk);
      seen[t] = {grant, mem_addr};
    end
    mem_ack = 1;
    @(negedge clk);
    mem_ack = 0;
    @(negedge clk);
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (seen[t] !== want[t]) begin
        errors++; $display("FAIL tie_grant%0d: got g/addr %h expected %h", t, seen[t], want[t]);
      end
    end
    checks++;
    if ({overrun, busy, mem_req} !== {2'b10, 1'b0, 1'b0}) begin
      errors++; $display("FAIL tie_end: got ovr=%b busy=%b req=%b expected 10 0 0",
                         overrun, busy, mem_req);
    end
  endtask

  task automatic test_overrun();
    int reqs;
    do_reset();
    p0_request = 1; p0_request_address = 16'h0030;
    @(negedge clk);
    p0_request_address = 16'h0031;
    @(negedge clk);
    p0_request = 0;
    checks++;
    if ({overrun, mem_req, mem_addr} !== {2'b01, 1'b1, 16'h0030}) begin
      errors++; $display("FAIL overrun_flag: got ovr=%b req=%b addr=%h expected 01 1 0030",
                         overrun, mem_req, mem_addr);
    end
    mem_ack = 1; mem_rdata = 16'h0C0C;
    @(negedge clk);
    mem_ack = 0;
    checks++;
    if ({p0_memory_ready, p0_memory_in} !== {1'b1, 16'h0C0C}) begin
      errors++; $display("FAIL overrun_first_done: got rdy=%b data=%h expected 1 0c0c",
                         p0_memory_ready, p0_memory_in);
    end
    reqs = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_req === 1'b1) reqs++;
    end
    checks++;
    if (reqs != 0 || overrun !== 2'b01) begin
      errors++; $display("FAIL overrun_dropped: got %0d issues ovr=%b expected 0 issues ovr=01",
                         reqs, overrun);
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    p0_request = 1; p0_request_address = 16'h0040;
    @(negedge clk);
    p0_request = 0;
    @(negedge clk);
    checks++;
    if ({mem_req, busy} !== 2'b11) begin
      errors++; $display("FAIL rstwait_issue: got req=%b busy=%b expected 1 1", mem_req, busy);
    end
    #2 reset_n = 0;
    #1;
    checks++;
    if (out_vec !== '0) begin
      errors++; $display("FAIL rstwait_async: got %h expected 0", out_vec);
    end
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    mem_ack = 1; mem_rdata = 16'h7777;
    @(negedge clk);
    mem_ack = 0;
    checks++;
    if (out_vec !== '0) begin
      errors++; $display("FAIL rstwait_late_ack: got %h expected 0", out_vec);
    end
    @(negedge clk);
    checks++;
    if (out_vec !== '0) begin
      errors++; $display("FAIL rstwait_after: got %h expected 0", out_vec);
    end
  endtask

  task automatic test_random(input int cycles);
    logic [OW-1:0] exp_vec;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      if (reset_n == 1'b0) reset_n = 1;
      else if ($urandom_range(0, 249) == 0) reset_n = 0;
      p0_request         = ($urandom_range(0, 3) == 0);
      p0_request_type    = $urandom_range(0, 1);
      p0_request_address = AW'($urandom);
      p0_data_out        = DW'($urandom);
      p1_request         = ($urandom_range(0, 3) == 0);
      p1_request_type    = $urandom_range(0, 1);
      p1_request_address = AW'($urandom);
      p1_data_out        = DW'($urandom);
      mem_ack            = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      mem_rdata          = DW'($urandom);
      @(negedge clk);
      exp_vec = {m_min[0], m_min[1], m_rdy[0], m_rdy[1], m_wc[0], m_wc[1], m_req, m_we,
                 m_addr, m_wd, (m_last == 1), m_busy, m_ovr};
      checks++;
      if (out_vec !== exp_vec) begin
        errors++; $display("FAIL random_cycle%0d: got %h expected %h", c, out_vec, exp_vec);
      end
      checks++;
      if ($countones({p0_memory_ready, p1_memory_ready, p0_write_complete, p1_write_complete}) > 1) begin
        errors++; $display("FAIL random_onehot%0d: got %b expected at most one pulse", c,
          {p0_memory_ready, p1_memory_ready, p0_write_complete, p1_write_complete});
      end
    end
    clear_inputs();
    reset_n = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read();
    test_spurious_ack();
    test_write();
    test_tie();
    test_overrun();
    test_reset_in_wait();
    test_random(3000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
